mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100, the number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter RD_LATENCY, default 1, the number of cycles mem_rd is held before mem_data_out is sampled (range 1..4).
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was rejected; no memory access occurred.
- mem_rd  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_add  out  32  word index = req_addr[31:2].
- mem_data_in  out  32  write data to memory.
- mem_data_out  in  32  read data from memory.

Function
REQ-004 SHALL implement the FSM states IDLE, RD, WR, RESP.
REQ-005 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready, and request fields SHALL be registered at acceptance.
REQ-006 SHALL flag an error when any of these holds: req_size==11; halfword with addr[0]!=0; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
REQ-007 SHALL route an accepted request to the next state as follows:
- error -> RESP.
- load, or store of byte/halfword -> RD.
- word store -> WR.
REQ-008 SHALL hold mem_rd=1 for exactly RD_LATENCY cycles in RD, then sample mem_data_out on the final RD cycle's clock edge.
REQ-009 SHALL leave RD for RESP on a load, or for WR on a sub-word store.
REQ-010 SHALL hold mem_we=1 for exactly one cycle in WR, then go to RESP.
REQ-011 SHALL, in WR, drive mem_data_in with the full req_wdata for a word store; for a sub-word store it SHALL drive the sampled word with only the addressed lane(s) replaced (little-endian; byte lane = addr[1:0], halfword lane = addr[1]).
REQ-012 SHALL never assert mem_rd and mem_we in the same cycle; both SHALL be 0 in IDLE, RESP, and on error paths.
REQ-013 SHALL drive mem_add and mem_data_in from registered values and hold them stable for the whole strobe duration.
REQ-014 SHALL extract load data from the addressed lane, extended per req_unsigned; word loads pass unchanged.
REQ-015 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1.
REQ-016 SHALL go RESP -> IDLE on resp_valid && resp_ready, with req_ready=1 the following cycle; there is no request/response overlap.
REQ-017 SHALL meet this latency from the acceptance edge to the first resp_valid cycle:
- error: 1.
- word store: 2.
- load: RD_LATENCY+1.
- sub-word store: RD_LATENCY+2.
REQ-018 SHALL ignore req_* inputs outside acceptance.

Reset
REQ-019 SHALL, on any edge with rst_n=0, enter IDLE and clear all outputs, including req_ready, regardless of current state.
REQ-020 SHALL abort an in-flight operation on reset: a pending RMW write is not issued, any strobe drops at that edge, and no response is produced.
REQ-021 SHALL assert req_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-022 SHALL cover these directed scenarios (memory word 50 preloaded to 0x000000AA, RD_LATENCY=1):
- Word load at addr 0xC8 -> mem_rd one cycle with mem_add=50; resp_rdata=0x000000AA, resp_err=0, two cycles after acceptance.
- Byte store of 0x7F at 0xC9 -> one mem_rd cycle, then one mem_we cycle with mem_data_in=0x00007FAA; then a signed byte load at 0xC9 returns 0x0000007F.
- Byte store of 0x80 at 0xCB, then signed byte load at 0xCB -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
- Halfword load at 0xCB, word load at 0x190 (index 100), and req_size=11 -> each gives resp_err=1 and resp_rdata=0 after 1 cycle, with mem_rd and mem_we never asserted.
- resp_ready held low 3 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0 throughout.
- rst_n low during RD of a sub-word store -> no mem_we ever; outputs 0; after release word 50 is unchanged and req_ready=1 on the next cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundles the request, response and memory-bus signals of mem_access_unit.
// No logic or latency of its own; it only carries wires between endpoints.
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
// Modports:
//   slave  - the access unit: takes requests, produces responses, drives the memory strobes.
//   master - the environment: issues requests, consumes responses, returns memory read data.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_we;
  logic [31:0] mem_add;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd, mem_we, mem_add, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd, mem_we, mem_add, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide data memory (sub-word stores via RMW).
// Latency from acceptance to response: error 1, word store 2, load RD_LATENCY+1, sub-word store RD_LATENCY+2.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Ports: clk, rst_n (synchronous, active-low); bus (mem_access_unit_if.slave) carries
//   req_* request channel, resp_* response channel, mem_* memory strobes/address/data.
module mem_access_unit #(
  parameter int MEM_WORDS  = 100,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [1:0]  RD_LAST     = 2'(RD_LATENCY - 1);

  state_t      state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [1:0]  rd_cnt;

  logic        accept;
  logic        req_err;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   if (bus.req_addr[0]) req_err = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W) req_err = 1'b1;
  end

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = w;
    res = w;
    case (sz)
      2'b00: begin
        sh  = w >> {off, 3'b000};
        res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = w >> {off[1], 4'b0000};
        res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = w;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/halfword lane of the word read back from memory.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    logic [31:0] d;
    if (sz == 2'b00) begin
      m = 32'h0000_00FF << {off, 3'b000};
      d = {24'h0, wd[7:0]} << {off, 3'b000};
    end else begin
      m = 32'h0000_FFFF << {off[1], 4'b0000};
      d = {16'h0, wd[15:0]} << {off[1], 4'b0000};
    end
    return (w & ~m) | (d & m);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Abort anything in flight: strobes drop, no pending RMW write, no response.
      state           <= IDLE;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= 32'h0;
      bus.resp_err    <= 1'b0;
      bus.mem_rd      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_add     <= 32'h0;
      bus.mem_data_in <= 32'h0;
      r_we            <= 1'b0;
      r_size          <= 2'b00;
      r_uns           <= 1'b0;
      r_off           <= 2'b00;
      r_wdata         <= 32'h0;
      rd_cnt          <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // req_ready comes up one cycle after reset release and stays up while idle.
          bus.req_ready <= 1'b1;
          if (accept) begin
            bus.req_ready <= 1'b0;
            r_we          <= bus.req_we;
            r_size        <= bus.req_size;
            r_uns         <= bus.req_unsigned;
            r_off         <= bus.req_addr[1:0];
            r_wdata       <= bus.req_wdata;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else begin
              bus.mem_add <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_we && bus.req_size == 2'b10) begin
                state           <= WR;
                bus.mem_we      <= 1'b1;
                bus.mem_data_in <= bus.req_wdata;
              end else begin
                // Loads and sub-word stores both need the current word first.
                state      <= RD;
                bus.mem_rd <= 1'b1;
                rd_cnt     <= 2'b00;
              end
            end
          end
        end

        RD: begin
          if (rd_cnt == RD_LAST) begin
            bus.mem_rd <= 1'b0;
            if (r_we) begin
              state           <= WR;
              bus.mem_we      <= 1'b1;
              bus.mem_data_in <= merge(bus.mem_data_out, r_wdata, r_size, r_off);
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= load_ext(bus.mem_data_out, r_size, r_off, r_uns);
            end
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end

        WR: begin
          bus.mem_we     <= 1'b0;
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0;
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// stall and reset-abort sequences, then random requests against a byte-array model.
module tb_mem_access_unit;

  localparam int WORDS = 100;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(WORDS), .RD_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word-wide data memory seen by the DUT.
  logic [31:0] mem [0:WORDS-1];

  assign bus.mem_data_out = (bus.mem_add < 32'(WORDS)) ? mem[bus.mem_add[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
      mem[50] <= 32'h0000_00AA;
    end else if (bus.mem_we && bus.mem_add < 32'(WORDS)) begin
      mem[bus.mem_add[6:0]] <= bus.mem_data_in;
    end
  end

  // Strobe monitor.
  int rd_mon = 0;
  int we_mon = 0;
  int both_mon = 0;
  logic [31:0] last_wdat = 32'h0;

  always @(posedge clk) begin
    if (bus.mem_rd) rd_mon++;
    if (bus.mem_we) begin
      we_mon++;
      last_wdat = bus.mem_data_in;
    end
    if (bus.mem_rd && bus.mem_we) both_mon++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  logic [7:0] ref_bytes [0:4*WORDS-1];

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int lat, output int rdn, output int wen);
    int n;
    int base;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= WORDS);
    rdata = 32'h0; lat = 1; rdn = 0; wen = 0;
    if (err) return;
    base = int'(addr);
    if (we) begin
      for (int i = 0; i < n; i++) ref_bytes[base + i] = 8'(wdata >> (8 * i));
      wen = 1;
      if (n == 4) begin lat = 2; rdn = 0; end
      else begin lat = LAT + 2; rdn = LAT; end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
      if (!uns && n == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      if (!uns && n == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      rdata = v; lat = LAT + 1; rdn = LAT;
    end
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // One complete request/response transaction, starting and ending on a falling edge.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input logic [31:0] stall_exp,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rdn, output int wen, output logic [31:0] wdat);
    int w;
    int rd0;
    int we0;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.req_ready) check({name, " req_ready wait"}, 32'(bus.req_ready), 32'd1);
    rd0 = rd_mon; we0 = we_mon;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      // Garbage while busy must be ignored.
      bus.req_valid = 1'b1; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
      bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    end while (!bus.resp_valid && lat < 20);
    if (!bus.resp_valid) check({name, " resp timeout"}, 32'(bus.resp_valid), 32'd1);
    rdata = bus.resp_rdata; err = bus.resp_err;
    rdn = rd_mon - rd0; wen = we_mon - we0; wdat = last_wdat;
    for (int s = 0; s < stall; s++) begin
      check({name, " stall resp_valid"}, 32'(bus.resp_valid), 32'd1);
      check({name, " stall rdata"}, bus.resp_rdata, stall_exp);
      check({name, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({name, " req_ready after resp"}, 32'(bus.req_ready), 32'd1);
    check({name, " resp_valid dropped"}, 32'(bus.resp_valid), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_we;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string nm, input logic we, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input int el,
                              input int erd, input int ewe, input logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_rd = erd; v.exp_we = ewe;
    v.exp_wdat = ewd;
    vq.push_back(v);
  endfunction

  initial begin
    logic [31:0] rdata, mrdata, wdat, addr, wdata;
    logic        err, merr, we, uns;
    logic [1:0]  size;
    int          lat, rdn, wen, mlat, mrd, mwe, we0, diffs, r;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 4 * WORDS; i++) ref_bytes[i] = 8'h00;
    ref_bytes[200] = 8'hAA;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset mem_rd", 32'(bus.mem_rd), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    rst_n = 1'b1; preload = 1'b0;
    @(negedge clk);
    check("req_ready after release", 32'(bus.req_ready), 32'd1);

    // Directed vectors (RD_LATENCY = 1, word 50 starts at 0x000000AA).
    add("ld_w_c8",      0, 2'b10, 0, 32'hC8,  32'h0,        32'h0000_00AA, 0, 2, 1, 0, 32'h0);
    add("st_b_7f_c9",   1, 2'b00, 0, 32'hC9,  32'h0000_007F, 32'h0,        0, 3, 1, 1, 32'h0000_7FAA);
    add("ld_sb_c9",     0, 2'b00, 0, 32'hC9,  32'h0,        32'h0000_007F, 0, 2, 1, 0, 32'h0);
    add("st_b_80_cb",   1, 2'b00, 0, 32'hCB,  32'hFFFF_FF80, 32'h0,        0, 3, 1, 1, 32'h8000_7FAA);
    add("ld_sb_cb",     0, 2'b00, 0, 32'hCB,  32'h0,        32'hFFFF_FF80, 0, 2, 1, 0, 32'h0);
    add("ld_ub_cb",     0, 2'b00, 1, 32'hCB,  32'h0,        32'h0000_0080, 0, 2, 1, 0, 32'h0);
    add("ld_h_cb_err",  0, 2'b01, 0, 32'hCB,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add("ld_w_190_err", 0, 2'b10, 0, 32'h190, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add("size11_err",   0, 2'b11, 0, 32'hC8,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    add("st_h_ca",      1, 2'b01, 0, 32'hCA,  32'h1234_ABCD, 32'h0,        0, 3, 1, 1, 32'hABCD_7FAA);
    add("ld_sh_ca",     0, 2'b01, 0, 32'hCA,  32'h0,        32'hFFFF_ABCD, 0, 2, 1, 0, 32'h0);
    add("ld_uh_ca",     0, 2'b01, 1, 32'hCA,  32'h0,        32'h0000_ABCD, 0, 2, 1, 0, 32'h0);
    add("st_w_0",       1, 2'b10, 0, 32'h0,   32'h1234_5678, 32'h0,        0, 2, 0, 1, 32'h1234_5678);
    add("ld_w_0",       0, 2'b10, 0, 32'h0,   32'h0,        32'h1234_5678, 0, 2, 1, 0, 32'h0);
    add("st_w_18c",     1, 2'b10, 0, 32'h18C, 32'hDEAD_BEEF, 32'h0,        0, 2, 0, 1, 32'hDEAD_BEEF);
    add("ld_ub_18f",    0, 2'b00, 1, 32'h18F, 32'h0,        32'h0000_00DE, 0, 2, 1, 0, 32'h0);
    add("ld_sb_18f",    0, 2'b00, 0, 32'h18F, 32'h0,        32'hFFFF_FFDE, 0, 2, 1, 0, 32'h0);
    add("st_w_2_err",   1, 2'b10, 0, 32'h2,   32'hFFFF_FFFF, 32'h0,        1, 1, 0, 0, 32'h0);

    foreach (vq[i]) begin
      model(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, mrdata, merr, mlat, mrd, mwe);
      do_req(vq[i].name, vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, 0, 32'h0,
             rdata, err, lat, rdn, wen, wdat);
      check({vq[i].name, " rdata"}, rdata, vq[i].exp_rdata);
      check({vq[i].name, " err"}, 32'(err), 32'(vq[i].exp_err));
      check({vq[i].name, " latency"}, 32'(lat), 32'(vq[i].exp_lat));
      check({vq[i].name, " rd cycles"}, 32'(rdn), 32'(vq[i].exp_rd));
      check({vq[i].name, " we cycles"}, 32'(wen), 32'(vq[i].exp_we));
      if (vq[i].exp_we != 0) check({vq[i].name, " mem_data_in"}, wdat, vq[i].exp_wdat);
    end

    // Response stall: resp_ready low for 3 cycles.
    model(1'b0, 2'b10, 1'b0, 32'hC8, 32'h0, mrdata, merr, mlat, mrd, mwe);
    do_req("stall", 1'b0, 2'b10, 1'b0, 32'hC8, 32'h0, 3, mrdata, rdata, err, lat, rdn, wen, wdat);
    check("stall rdata", rdata, 32'hABCD_7FAA);
    check("stall latency", 32'(lat), 32'(mlat));

    // Reset during the RD phase of a sub-word store.
    we0 = we_mon;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'hC9; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst: mem_rd in RD", 32'(bus.mem_rd), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst: mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst: mem_we", 32'(bus.mem_we), 32'd0);
    check("rst: req_ready", 32'(bus.req_ready), 32'd0);
    check("rst: resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst: resp_rdata", bus.resp_rdata, 32'h0);
    check("rst: mem_add", bus.mem_add, 32'h0);
    check("rst: mem_data_in", bus.mem_data_in, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst: req_ready after release", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst: no response", 32'(bus.resp_valid), 32'd0);
    check("rst: no write", 32'(we_mon - we0), 32'd0);
    check("rst: word 50 unchanged", mem[50], ref_word(50));

    // Random requests against the byte-array model.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 415));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr = addr & 32'hFFFF_FFFE;
        if (size == 2'd2) addr = addr & 32'hFFFF_FFFC;
      end
      wdata = $urandom;
      model(we, size, uns, addr, wdata, mrdata, merr, mlat, mrd, mwe);
      do_req($sformatf("rnd%0d", i), we, size, uns, addr, wdata, 0, 32'h0,
             rdata, err, lat, rdn, wen, wdat);
      check($sformatf("rnd%0d rdata a=%h", i, addr), rdata, mrdata);
      check($sformatf("rnd%0d err", i), 32'(err), 32'(merr));
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d rd cycles", i), 32'(rdn), 32'(mrd));
      check($sformatf("rnd%0d we cycles", i), 32'(wen), 32'(mwe));
    end

    diffs = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_word(i)) diffs++;
    check("final memory words differing", 32'(diffs), 32'd0);
    check("mem_rd and mem_we overlap cycles", 32'(both_mon), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
